// File: rtl/mux_8_1_reg_if.sv
// Bundle of the selector's data, select and result signals.
// The master side drives the eight data words and the three select bits
// and observes the registered result; the slave side is the selector.
interface mux_8_1_reg_if #(
  parameter int WIDTH = 1
);

  // Eight candidate data words, D0 selected by 3'b000 up to D7 by 3'b111.
  logic [WIDTH-1:0] D0;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic [WIDTH-1:0] D3;
  logic [WIDTH-1:0] D4;
  logic [WIDTH-1:0] D5;
  logic [WIDTH-1:0] D6;
  logic [WIDTH-1:0] D7;

  // Select bits; S0 is the LSB of the index {S2,S1,S0}.
  logic             S0;
  logic             S1;
  logic             S2;

  // Registered selection result.
  logic [WIDTH-1:0] out;

  modport master (
    output D0, D1, D2, D3, D4, D5, D6, D7,
    output S0, S1, S2,
    input  out
  );

  modport slave (
    input  D0, D1, D2, D3, D4, D5, D6, D7,
    input  S0, S1, S2,
    output out
  );

endinterface : mux_8_1_reg_if

// File: rtl/mux_8_1_reg.sv
// Registered 8-to-1 multiplexer.
// The word chosen by {S2,S1,S0} is captured on each rising clock edge and
// held on out, so downstream logic sees a glitch-free value that changes
// only on a clock edge or when rst_n falls. There is no combinational
// path from any input to out.
module mux_8_1_reg #(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_8_1_reg_if.slave  bus
);

  logic [2:0]       sel;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] out_q;

  assign sel = {bus.S2, bus.S1, bus.S0};

  // Pick the word addressed by sel; all eight arms are mutually exclusive.
  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path
    // assigned, so no latch can be inferred even if an arm is removed.
    nxt = '0;
    case (sel)
      3'b000:  nxt = bus.D0;
      3'b001:  nxt = bus.D1;
      3'b010:  nxt = bus.D2;
      3'b011:  nxt = bus.D3;
      3'b100:  nxt = bus.D4;
      3'b101:  nxt = bus.D5;
      3'b110:  nxt = bus.D6;
      3'b111:  nxt = bus.D7;
      // An unknown select carries no meaningful data; drive zero.
      default: nxt = '0;
    endcase
  end

  // Capture the selected word each edge; reset clears out immediately and
  // drops whatever sample was about to be taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignment so every register updates from
      // values sampled before the edge, never from this edge's results.
      out_q <= '0;
    end else begin
      out_q <= nxt;
    end
  end

  assign bus.out = out_q;

endmodule : mux_8_1_reg

// File: tb/tb_mux_8_1_reg.sv
// Testbench for mux_8_1_reg. Runs a 1-bit and an 8-bit instance side by
// side from one clock and reset. Each cycle the bench drives inputs on the
// falling edge, queues the word it expects for each instance, and pops and
// compares one entry per instance just after the following rising edge.
module tb_mux_8_1_reg;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mux_8_1_reg_if #(.WIDTH(1)) if1 ();
  mux_8_1_reg_if #(.WIDTH(8)) if8 ();

  mux_8_1_reg #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  mux_8_1_reg #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  // Bench-side copies of the stimulus.
  logic       d1 [8];
  logic [7:0] d8 [8];
  logic [2:0] sel;

  // Scoreboards of expected outputs, one per instance.
  logic       q1 [$];
  logic [7:0] q8 [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    if1.D0 = d1[0]; if1.D1 = d1[1]; if1.D2 = d1[2]; if1.D3 = d1[3];
    if1.D4 = d1[4]; if1.D5 = d1[5]; if1.D6 = d1[6]; if1.D7 = d1[7];
    if8.D0 = d8[0]; if8.D1 = d8[1]; if8.D2 = d8[2]; if8.D3 = d8[3];
    if8.D4 = d8[4]; if8.D5 = d8[5]; if8.D6 = d8[6]; if8.D7 = d8[7];
    {if1.S2, if1.S1, if1.S0} = sel;
    {if8.S2, if8.S1, if8.S0} = sel;
  endtask

  // Drive one cycle of stimulus (called on a falling edge), then compare
  // both instances just after the next rising edge and return on the
  // following falling edge.
  task automatic step(input string tag);
    logic       e1;
    logic [7:0] e8;
    drive();
    q1.push_back(d1[sel]);
    q8.push_back(d8[sel]);
    @(posedge clk);
    #1;
    if (q1.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_w1: observed %h expected <no queued entry>", tag, if1.out);
    end else begin
      e1 = q1.pop_front();
      check({tag, "_w1"}, {7'd0, if1.out}, {7'd0, e1});
    end
    if (q8.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_w8: observed %h expected <no queued entry>", tag, if8.out);
    end else begin
      e8 = q8.pop_front();
      check({tag, "_w8"}, if8.out, e8);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      d1[k] = 1'b1;
      d8[k] = 8'h10 + 8'(k);
    end
    sel = 3'b011;
    drive();

    // Reset held: out stays zero with and without clock edges.
    #1;
    check("rst_noedge_w1", {7'd0, if1.out}, 8'h00);
    check("rst_noedge_w8", if8.out, 8'h00);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold_w1", {7'd0, if1.out}, 8'h00);
      check("rst_hold_w8", if8.out, 8'h00);
    end

    // First edge after release loads D[sel].
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_release");
    check("rst_release_13", if8.out, 8'h13);

    // Alternating pattern, each select held two cycles.
    for (int k = 0; k < 8; k++) d1[k] = k[0];
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step("alt_a");
      step("alt_b");
      check("alt_val", {7'd0, if1.out}, {7'd0, s[0]});
    end

    // Walking one across all select values.
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) d1[j] = (j == k);
      for (int s = 0; s < 8; s++) begin
        sel = 3'(s);
        step("walk");
      end
    end

    // Fixed select 5: out tracks D5, ignores D4/D6.
    sel = 3'b101;
    for (int j = 0; j < 8; j++) d1[j] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      d1[5] = ~d1[5];
      step("track_d5");
    end
    d1[5] = 1'b1;
    step("track_set");
    for (int c = 0; c < 4; c++) begin
      d1[4] = ~d1[4];
      d1[6] = ~d1[6];
      d8[4] = d8[4] ^ 8'hff;
      d8[6] = d8[6] ^ 8'h5a;
      step("ignore_d46");
      check("ignore_d46_hold_w1", {7'd0, if1.out}, 8'h01);
      check("ignore_d46_hold_w8", if8.out, 8'h15);
    end
    for (int k = 0; k < 8; k++) d8[k] = 8'h10 + 8'(k);

    // Wide instance at the two select values of interest.
    sel = 3'b011;
    step("w8_s3");
    check("w8_s3_13", if8.out, 8'h13);
    sel = 3'b111;
    step("w8_s7");
    check("w8_s7_17", if8.out, 8'h17);

    // Asynchronous reset between edges while out is nonzero.
    for (int k = 0; k < 8; k++) d1[k] = 1'b1;
    sel = 3'b010;
    step("pre_async");
    check("pre_async_w1", {7'd0, if1.out}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr_w1", {7'd0, if1.out}, 8'h00);
    check("async_clr_w8", if8.out, 8'h00);
    @(posedge clk);
    #1;
    check("async_hold_w1", {7'd0, if1.out}, 8'h00);
    check("async_hold_w8", if8.out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    sel = 3'b110;
    step("post_async");
    check("post_async_16", if8.out, 8'h16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_8_1_reg
